// File: rtl/l2_icache_ctrl_pkg.sv
// Shared encodings for the L2-side instruction-cache miss responder.
package l2_icache_ctrl_pkg;

  // Request opcodes on icache_l2_op
  localparam logic [2:0] L2OP_NOP    = 3'b000;
  localparam logic [2:0] L2OP_FILL   = 3'b001;
  localparam logic [2:0] L2OP_PREF   = 3'b010;
  localparam logic [2:0] L2OP_CANCEL = 3'b011;
  // Response opcode on l2_icache_op (shares the 010 code with PREF on the other direction)
  localparam logic [2:0] L2OP_INV    = 3'b010;

  // Coherence states carried on l2_icache_state
  localparam logic [2:0] ST_I = 3'b000;
  localparam logic [2:0] ST_S = 3'b001;

  // 64-byte lines
  localparam int LINE_OFF = 6;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ISSUE = 2'd1,
    FSM_WAIT  = 2'd2,
    FSM_RESP  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/l2_icache_ctrl_req_fifo.sv
// Request queue: CAM-searchable FIFO with per-entry demand bits, duplicate
// merging, demand promotion and order-preserving removal for CANCEL/INV.
module l2_req_fifo
  import l2_icache_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  input  logic            push_demand,
  input  logic [XLEN-1:0] push_line,
  input  logic            pop,
  input  logic            cancel,
  input  logic            inv_valid,
  input  logic [XLEN-1:0] inv_line,
  input  logic            busy,
  input  logic [XLEN-1:0] busy_line,
  output logic            head_valid,
  output logic [XLEN-1:0] head_line,
  output logic [CW-1:0]   count_next
);

  localparam logic [CW-1:0] FULL_CNT   = CW'(QDEPTH);
  localparam logic [CW-1:0] PREF_LIMIT = CW'(QDEPTH - 1);

  logic [XLEN-1:0]   q_line [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [QDEPTH-1:0] q_dem;
  logic [CW-1:0]     q_cnt;

  logic [QDEPTH-1:0] p_dem;
  logic [XLEN-1:0]   s_line [QDEPTH];
  logic [QDEPTH-1:0] s_vld;
  logic [QDEPTH-1:0] s_dem;
  logic [XLEN-1:0]   n_line [QDEPTH];
  logic [QDEPTH-1:0] n_vld;
  logic [QDEPTH-1:0] n_dem;
  logic              hit;
  logic              keep;
  logic [CW-1:0]     wr_idx;

  // Next queue contents: merge/promote, pop, filter+compact, then append
  always_comb begin
    hit    = 1'b0;
    keep   = 1'b0;
    p_dem  = q_dem;
    // Merge lookup against live entries (an entry killed by INV this cycle does not count)
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i] && (q_line[i] == push_line) && !(inv_valid && (q_line[i] == inv_line))) begin
        hit = 1'b1;
        if (push_demand) p_dem[i] = 1'b1;
      end
    end
    if (busy && (busy_line == push_line)) hit = 1'b1;

    // Pop shifts everything down by one slot
    s_line = q_line;
    s_vld  = q_vld;
    s_dem  = p_dem;
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        s_line[i] = q_line[i+1];
        s_vld[i]  = q_vld[i+1];
        s_dem[i]  = p_dem[i+1];
      end
      s_line[QDEPTH-1] = '0;
      s_vld[QDEPTH-1]  = 1'b0;
      s_dem[QDEPTH-1]  = 1'b0;
    end

    // Drop cancelled prefetches and invalidated lines, keeping order
    n_line = '{default: '0};
    n_vld  = '0;
    n_dem  = '0;
    wr_idx = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      keep = s_vld[i] && !(cancel && !s_dem[i]) && !(inv_valid && (s_line[i] == inv_line));
      if (keep) begin
        for (int j = 0; j < QDEPTH; j++) begin
          if (CW'(j) == wr_idx) begin
            n_line[j] = s_line[i];
            n_vld[j]  = 1'b1;
            n_dem[j]  = s_dem[i];
          end
        end
        wr_idx = wr_idx + CW'(1);
      end
    end

    // Append a new line; prefetches never take the last free slot
    if (push_valid && !hit && (wr_idx != FULL_CNT) && (push_demand || (q_cnt < PREF_LIMIT))) begin
      for (int j = 0; j < QDEPTH; j++) begin
        if (CW'(j) == wr_idx) begin
          n_line[j] = push_line;
          n_vld[j]  = 1'b1;
          n_dem[j]  = push_demand;
        end
      end
      wr_idx = wr_idx + CW'(1);
    end
    count_next = wr_idx;
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) q_line[i] <= '0;
      q_vld <= '0;
      q_dem <= '0;
      q_cnt <= '0;
    end else begin
      q_line <= n_line;
      q_vld  <= n_vld;
      q_dem  <= n_dem;
      q_cnt  <= wr_idx;
    end
  end

  assign head_valid = q_vld[0];
  assign head_line  = q_line[0];

endmodule

// File: rtl/l2_icache_ctrl.sv
// L2-side responder for icache misses: queues fill/prefetch requests, fetches
// each line from memory and returns it as a one-cycle FILL; forwards
// coherence invalidates as one-cycle INV pulses.
//
// Handshake: mem_req_valid rises with a registered, stable mem_req_addr and
// stays high until the cycle mem_req_ready is also high; the transfer happens
// on that edge. mem_resp_valid is a one-way strobe, only honoured in WAIT.
// The frontend has no ready: every FILL/INV pulse is consumed as presented.
module l2_icache_ctrl
  import l2_icache_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LINE_BITS = 512,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           icache_l2_op,
  input  logic [2:0]           icache_l2_state,
  input  logic [XLEN-1:0]      icache_l2_addr,
  input  logic [LINE_BITS-1:0] icache_l2_data_out,
  output logic                 l2_icache_stall,
  output logic [2:0]           l2_icache_op,
  output logic [2:0]           l2_icache_state,
  output logic [XLEN-1:0]      l2_icache_addr,
  output logic [LINE_BITS-1:0] l2_icache_data_in,
  input  logic                 inv_valid,
  input  logic [XLEN-1:0]      inv_addr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [XLEN-1:0]      mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data,
  output fsm_state_t           dbg_state
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  fsm_state_t      state;
  logic [XLEN-1:0] cur_line;
  logic            inv_pend;
  logic [XLEN-1:0] inv_pend_line;

  logic [XLEN-1:0] req_line;
  logic [XLEN-1:0] inv_line;
  logic            push_valid;
  logic            push_demand;
  logic            cancel;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] head_line;
  logic [CW-1:0]   count_next;
  logic            fill_now;
  logic            inv_any;
  logic [XLEN-1:0] inv_any_line;
  logic            unused_inputs;

  assign req_line = {icache_l2_addr[XLEN-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign inv_line = {inv_addr[XLEN-1:LINE_OFF], {LINE_OFF{1'b0}}};

  // The icache is read-only: its state/data fields and the byte offsets carry nothing
  assign unused_inputs = ^{icache_l2_state, icache_l2_data_out,
                           icache_l2_addr[LINE_OFF-1:0], inv_addr[LINE_OFF-1:0]};

  // Request decode; everything from the frontend is ignored while stalled
  always_comb begin
    push_valid  = !l2_icache_stall && ((icache_l2_op == L2OP_FILL) || (icache_l2_op == L2OP_PREF));
    push_demand = (icache_l2_op == L2OP_FILL);
    cancel      = !l2_icache_stall && (icache_l2_op == L2OP_CANCEL);
    pop         = (state == FSM_IDLE) && head_valid;
    fill_now    = (state == FSM_WAIT) && mem_resp_valid;
    // A fresh invalidate overwrites any one still pending
    inv_any      = inv_valid || inv_pend;
    inv_any_line = inv_valid ? inv_line : inv_pend_line;
  end

  l2_req_fifo #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_demand (push_demand),
    .push_line   (req_line),
    .pop         (pop),
    .cancel      (cancel),
    .inv_valid   (inv_valid),
    .inv_line    (inv_line),
    .busy        (state != FSM_IDLE),
    .busy_line   (cur_line),
    .head_valid  (head_valid),
    .head_line   (head_line),
    .count_next  (count_next)
  );

  // Fetch FSM, invalidate holding register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= FSM_IDLE;
      cur_line          <= '0;
      inv_pend          <= 1'b0;
      inv_pend_line     <= '0;
      l2_icache_stall   <= 1'b0;
      l2_icache_op      <= L2OP_NOP;
      l2_icache_state   <= ST_I;
      l2_icache_addr    <= '0;
      l2_icache_data_in <= '0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= '0;
    end else begin
      l2_icache_stall   <= (count_next == FULL_CNT);
      l2_icache_op      <= L2OP_NOP;
      l2_icache_state   <= ST_I;
      l2_icache_addr    <= '0;
      l2_icache_data_in <= '0;
      case (state)
        FSM_IDLE: begin
          if (head_valid) begin
            cur_line      <= head_line;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= head_line;
            state         <= FSM_ISSUE;
          end
        end
        FSM_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            state         <= FSM_WAIT;
          end
        end
        FSM_WAIT: begin
          if (mem_resp_valid) begin
            l2_icache_op      <= L2OP_FILL;
            l2_icache_state   <= ST_S;
            l2_icache_addr    <= cur_line;
            l2_icache_data_in <= mem_resp_data;
            state             <= FSM_RESP;
          end
        end
        default: state <= FSM_IDLE;
      endcase
      // The FILL pulse owns the output; an invalidate waits one cycle behind it
      if (fill_now) begin
        if (inv_valid) begin
          inv_pend      <= 1'b1;
          inv_pend_line <= inv_line;
        end
      end else if (inv_any) begin
        l2_icache_op    <= L2OP_INV;
        l2_icache_state <= ST_I;
        l2_icache_addr  <= inv_any_line;
        inv_pend        <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_l2_icache_ctrl.sv
// Directed bench for l2_icache_ctrl: cycle table for latency/INV ordering,
// hand sequences for merge, prefetch limit, stall, CANCEL, INV removal, reset.
module tb_l2_icache_ctrl;
  import l2_icache_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int LB   = 512;
  localparam logic [LB-1:0] PAT_A = {16{32'hA5A5_1234}};
  localparam logic [LB-1:0] PAT_B = {8{64'h0123_4567_89AB_CDEF}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      icache_l2_op;
  logic [2:0]      icache_l2_state;
  logic [XLEN-1:0] icache_l2_addr;
  logic [LB-1:0]   icache_l2_data_out;
  logic            l2_icache_stall;
  logic [2:0]      l2_icache_op;
  logic [2:0]      l2_icache_state;
  logic [XLEN-1:0] l2_icache_addr;
  logic [LB-1:0]   l2_icache_data_in;
  logic            inv_valid;
  logic [XLEN-1:0] inv_addr;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [LB-1:0]   mem_resp_data;
  fsm_state_t      dbg_state;

  l2_icache_ctrl #(.XLEN(XLEN), .LINE_BITS(LB), .QDEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .icache_l2_op       (icache_l2_op),
    .icache_l2_state    (icache_l2_state),
    .icache_l2_addr     (icache_l2_addr),
    .icache_l2_data_out (icache_l2_data_out),
    .l2_icache_stall    (l2_icache_stall),
    .l2_icache_op       (l2_icache_op),
    .l2_icache_state    (l2_icache_state),
    .l2_icache_addr     (l2_icache_addr),
    .l2_icache_data_in  (l2_icache_data_in),
    .inv_valid          (inv_valid),
    .inv_addr           (inv_addr),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] req_log[$];
  logic [XLEN-1:0] fill_log[$];
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_fill_q[$];

  task automatic chk(input string name, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare observed memory requests / FILLs against the expected queues, then clear all
  task automatic check_logs(input string name);
    chk({name, " req count"}, LB'(req_log.size()), LB'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
      chk($sformatf("%s req[%0d]", name, i), LB'(req_log[i]), LB'(exp_q[i]));
    chk({name, " fill count"}, LB'(fill_log.size()), LB'(exp_fill_q.size()));
    for (int i = 0; i < exp_fill_q.size() && i < fill_log.size(); i++)
      chk($sformatf("%s fill[%0d]", name, i), LB'(fill_log[i]), LB'(exp_fill_q[i]));
    req_log.delete();
    fill_log.delete();
    exp_q.delete();
    exp_fill_q.delete();
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs; log handshakes and FILLs mid-cycle; return #1 after the edge
  task automatic step(input logic [2:0] op, input logic [XLEN-1:0] addr,
                      input logic iv, input logic [XLEN-1:0] ia,
                      input logic rdy, input logic rv, input logic [LB-1:0] rd);
    icache_l2_op   = op;
    icache_l2_addr = addr;
    inv_valid      = iv;
    inv_addr       = ia;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
    if (l2_icache_op == L2OP_FILL) fill_log.push_back(l2_icache_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rdy, input logic rv);
    repeat (n) step(L2OP_NOP, '0, 1'b0, '0, rdy, rv, PAT_A);
  endtask

  function automatic logic [LB-1:0] dsel_data(input logic [1:0] s);
    case (s)
      2'd1:    return PAT_A;
      2'd2:    return PAT_B;
      default: return '0;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] addr;
    logic            iv;
    logic [XLEN-1:0] ia;
    logic            rdy;
    logic            rv;
    logic [1:0]      rsel;
    logic            e_stall;
    logic [2:0]      e_op;
    logic [2:0]      e_st;
    logic [XLEN-1:0] e_addr;
    logic [1:0]      e_dsel;
    logic            e_mrv;
    logic [XLEN-1:0] e_mra;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [XLEN-1:0] addr,
                         input logic iv, input logic [XLEN-1:0] ia,
                         input logic rdy, input logic rv, input logic [1:0] rsel,
                         input logic [2:0] e_op, input logic [2:0] e_st,
                         input logic [XLEN-1:0] e_addr, input logic [1:0] e_dsel,
                         input logic e_mrv, input logic [XLEN-1:0] e_mra);
    vec_t v;
    v.op = op; v.addr = addr; v.iv = iv; v.ia = ia; v.rdy = rdy; v.rv = rv; v.rsel = rsel;
    v.e_stall = 1'b0; v.e_op = e_op; v.e_st = e_st; v.e_addr = e_addr;
    v.e_dsel = e_dsel; v.e_mrv = e_mrv; v.e_mra = e_mra;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b0;
    icache_l2_op = L2OP_NOP; icache_l2_state = 3'b0; icache_l2_addr = '0;
    icache_l2_data_out = '0; inv_valid = 1'b0; inv_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", LB'(l2_icache_stall), LB'(1'b0));
    chk("reset op", LB'(l2_icache_op), LB'(L2OP_NOP));
    chk("reset mem_req_valid", LB'(mem_req_valid), LB'(1'b0));
    chk("reset data", l2_icache_data_in, '0);
    chk("reset fsm", LB'(dbg_state), LB'(FSM_IDLE));
    rst = 1'b1;

    //      op          addr          iv    ia            rdy   rv    rsel  e_op       e_st  e_addr        dsel  mrv   mra
    // FILL 0x1234, 1-cycle memory: FILL visible 4 edges after the request
    add_vec(L2OP_FILL, 32'h0000_1234, 1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b1, 32'h0000_1200);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 2'd1, L2OP_FILL, ST_S, 32'h0000_1200, 2'd1, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    // FILL 0x5008, invalidate 0x3004 arrives during the FILL cycle
    add_vec(L2OP_FILL, 32'h0000_5008, 1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b1, 32'h0000_5000);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 2'd2, L2OP_FILL, ST_S, 32'h0000_5000, 2'd2, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b1, 32'h0000_3004, 1'b1, 1'b0, 2'd0, L2OP_INV,  ST_I, 32'h0000_3000, 2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    // Stray memory response in IDLE is ignored
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 2'd1, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);
    // Invalidate while idle goes out on the next cycle
    add_vec(L2OP_NOP,  32'h0,         1'b1, 32'h0000_7000, 1'b1, 1'b0, 2'd0, L2OP_INV,  ST_I, 32'h0000_7000, 2'd0, 1'b0, 32'h0);
    add_vec(L2OP_NOP,  32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 2'd0, L2OP_NOP,  ST_I, 32'h0,        2'd0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].op, vecs[i].addr, vecs[i].iv, vecs[i].ia, vecs[i].rdy, vecs[i].rv, dsel_data(vecs[i].rsel));
      chk($sformatf("vec%0d stall", i), LB'(l2_icache_stall), LB'(vecs[i].e_stall));
      chk($sformatf("vec%0d op", i), LB'(l2_icache_op), LB'(vecs[i].e_op));
      chk($sformatf("vec%0d state", i), LB'(l2_icache_state), LB'(vecs[i].e_st));
      chk($sformatf("vec%0d addr", i), LB'(l2_icache_addr), LB'(vecs[i].e_addr));
      chk($sformatf("vec%0d data", i), l2_icache_data_in, dsel_data(vecs[i].e_dsel));
      chk($sformatf("vec%0d mem_req_valid", i), LB'(mem_req_valid), LB'(vecs[i].e_mrv));
      chk($sformatf("vec%0d mem_req_addr", i), LB'(mem_req_addr), LB'(vecs[i].e_mra));
    end
    req_log.delete();
    fill_log.delete();

    // Duplicate FILL and a same-line PREF merge into one fetch
    step(L2OP_FILL, 32'h0000_1000, 1'b0, '0, 1'b1, 1'b0, '0);
    step(L2OP_FILL, 32'h0000_1000, 1'b0, '0, 1'b1, 1'b0, '0);
    step(L2OP_PREF, 32'h0000_1010, 1'b0, '0, 1'b1, 1'b0, '0);
    run(12, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_1000);
    exp_fill_q.push_back(32'h0000_1000);
    check_logs("merge");

    // PREF limit and stall: 0x0 held in ISSUE, three PREFs queued, fourth PREF dropped
    step(L2OP_FILL, 32'h0000_0000, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_PREF, 32'h0000_0040, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_PREF, 32'h0000_0080, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_PREF, 32'h0000_00C0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("pref3 stall", LB'(l2_icache_stall), LB'(1'b0));
    step(L2OP_PREF, 32'h0000_0100, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("pref dropped stall", LB'(l2_icache_stall), LB'(1'b0));
    step(L2OP_FILL, 32'h0000_0200, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("full stall", LB'(l2_icache_stall), LB'(1'b1));
    step(L2OP_FILL, 32'h0000_0300, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("stall held", LB'(l2_icache_stall), LB'(1'b1));
    run(40, 1'b1, 1'b1);
    chk("stall released", LB'(l2_icache_stall), LB'(1'b0));
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0040); exp_q.push_back(32'h0000_0080);
    exp_q.push_back(32'h0000_00C0); exp_q.push_back(32'h0000_0200);
    exp_fill_q.push_back(32'h0000_0000); exp_fill_q.push_back(32'h0000_0040); exp_fill_q.push_back(32'h0000_0080);
    exp_fill_q.push_back(32'h0000_00C0); exp_fill_q.push_back(32'h0000_0200);
    check_logs("preflimit");

    // CANCEL drops queued PREFs only; in-flight 0x0 and demand 0xC0 survive
    step(L2OP_FILL,   32'h0000_0000, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_PREF,   32'h0000_0040, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_PREF,   32'h0000_0080, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_FILL,   32'h0000_00C0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_CANCEL, 32'h0000_0000, 1'b0, '0, 1'b0, 1'b0, '0);
    run(20, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_00C0);
    exp_fill_q.push_back(32'h0000_0000); exp_fill_q.push_back(32'h0000_00C0);
    check_logs("cancel");

    // INV removes a queued line; the in-flight line is still delivered
    step(L2OP_FILL, 32'h0000_4000, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_FILL, 32'h0000_8000, 1'b0, '0, 1'b0, 1'b0, '0);
    step(L2OP_NOP,  32'h0,         1'b1, 32'h0000_8020, 1'b0, 1'b0, '0);
    chk("inv queued op", LB'(l2_icache_op), LB'(L2OP_INV));
    chk("inv queued addr", LB'(l2_icache_addr), LB'(32'h0000_8000));
    step(L2OP_NOP,  32'h0,         1'b1, 32'h0000_4000, 1'b0, 1'b0, '0);
    run(15, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_4000);
    exp_fill_q.push_back(32'h0000_4000);
    check_logs("invremove");

    // Reset in WAIT abandons the fetch and empties the queue
    step(L2OP_FILL, 32'h0000_2000, 1'b0, '0, 1'b1, 1'b0, '0);
    step(L2OP_FILL, 32'h0000_2040, 1'b0, '0, 1'b1, 1'b0, '0);
    step(L2OP_NOP,  32'h0,         1'b0, '0, 1'b1, 1'b0, '0);
    chk("pre-reset fsm", LB'(dbg_state), LB'(FSM_WAIT));
    exp_q.push_back(32'h0000_2000);
    check_logs("prereset");
    #2 rst = 1'b0;
    #1;
    chk("async reset op", LB'(l2_icache_op), LB'(L2OP_NOP));
    chk("async reset mem_req_valid", LB'(mem_req_valid), LB'(1'b0));
    chk("async reset stall", LB'(l2_icache_stall), LB'(1'b0));
    chk("async reset fsm", LB'(dbg_state), LB'(FSM_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(12, 1'b1, 1'b1);
    chk("post-reset op", LB'(l2_icache_op), LB'(L2OP_NOP));
    chk("post-reset data", l2_icache_data_in, '0);
    check_logs("postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
